// File: rtl/switch_event_pkg.sv
// Shared constants and event record layout for the switch event queue.
package switch_event_pkg;

  localparam logic EV_RELEASE = 1'b0;
  localparam logic EV_PRESS   = 1'b1;

  // Event record is packed as {key[LOG2_KEYS-1:0], pressed}; pressed is the LSB.
  localparam int EV_PRESSED_BIT = 0;
  localparam int EV_KEY_LSB     = 1;

  function automatic int ev_width(input int log2_keys);
    return log2_keys + 1;
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Parameterised synchronous FIFO; head is read combinationally from storage.
module event_fifo
  import switch_event_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  output logic                  full,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  empty,
  output logic [LOG2_DEPTH:0]   count
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [LOG2_DEPTH-1:0]       wr_ptr, rd_ptr;
  logic                        do_push, do_pop;

  assign full    = (count == (LOG2_DEPTH+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage, wrapping pointers and occupancy count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/switch_event_queue.sv
// Turns debouncer on/off pulses into an ordered key event stream.
module switch_event_queue
  import switch_event_pkg::*;
#(
  parameter int N_KEYS     = 8,
  parameter int LOG2_KEYS  = 3,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_KEYS-1:0]     key_on,
  input  logic [N_KEYS-1:0]     key_off,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [LOG2_KEYS-1:0]  ev_key,
  output logic                  ev_pressed,
  output logic [LOG2_DEPTH:0]   ev_count,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int EW = ev_width(LOG2_KEYS);

  // Per-key pending stage: up to two events, oldest type in ptype.
  logic [1:0]           pcnt  [N_KEYS];
  logic                 ptype [N_KEYS];
  logic [N_KEYS-1:0]    xfer, drop;

  logic [LOG2_KEYS-1:0] win_key;
  logic                 win_type, win_any;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [EW-1:0]        fifo_rdata;

  // Fixed priority: lowest pending key index wins.
  always_comb begin
    win_key  = '0;
    win_type = 1'b0;
    win_any  = 1'b0;
    for (int k = N_KEYS-1; k >= 0; k--) begin
      if (pcnt[k] != 2'd0) begin
        win_key  = LOG2_KEYS'(k);
        win_type = ptype[k];
        win_any  = 1'b1;
      end
    end
  end

  assign fifo_pop  = ev_valid & ev_ready;
  assign fifo_push = win_any & (~fifo_full | fifo_pop);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic       pulse, pulse_type, type_left;
    logic [1:0] cnt_left;

    assign xfer[k]    = fifo_push & (win_key == LOG2_KEYS'(k));
    assign pulse      = key_on[k] | key_off[k];
    assign pulse_type = key_on[k] ? EV_PRESS : EV_RELEASE;
    // State after this edge's transfer, before any new pulse is absorbed.
    assign cnt_left   = pcnt[k] - {1'b0, xfer[k]};
    assign type_left  = ptype[k] ^ xfer[k];
    assign drop[k]    = pulse & (cnt_left == 2'd2);

    // Absorb new pulse into the slot freed (or not) by this edge's transfer.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        pcnt[k]  <= 2'd0;
        ptype[k] <= 1'b0;
      end else if (pulse && cnt_left == 2'd0) begin
        pcnt[k]  <= 2'd1;
        ptype[k] <= pulse_type;
      end else if (pulse && cnt_left == 2'd1) begin
        pcnt[k]  <= 2'd2;
        ptype[k] <= type_left;
      end else begin
        pcnt[k]  <= cnt_left;
        ptype[k] <= type_left;
      end
    end
  end

  // Sticky drop flag; a drop on the clearing edge keeps it set.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      overflow <= 1'b0;
    else if (|drop)
      overflow <= 1'b1;
    else if (clear_overflow)
      overflow <= 1'b0;
  end

  event_fifo #(
    .WIDTH      (EW),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wdata   ({win_key, win_type}),
    .full    (fifo_full),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .empty   (fifo_empty),
    .count   (ev_count)
  );

  assign ev_valid   = ~fifo_empty;
  assign ev_key     = fifo_empty ? '0 : fifo_rdata[EW-1:EV_KEY_LSB];
  assign ev_pressed = ~fifo_empty & fifo_rdata[EV_PRESSED_BIT];

endmodule

// File: tb/tb_switch_event_queue.sv
// Directed bench for switch_event_queue with default parameters.
module tb_switch_event_queue;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] key_on = '0, key_off = '0;
  logic       ev_valid, ev_ready = 1'b0, ev_pressed, overflow, clear_overflow = 1'b0;
  logic [2:0] ev_key, ev_count;

  int n_cmp = 0, n_bad = 0;
  logic [3:0] got[$];

  switch_event_queue dut (
    .clock(clock), .reset_n(reset_n), .key_on(key_on), .key_off(key_off),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_key(ev_key), .ev_pressed(ev_pressed),
    .ev_count(ev_count), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Collect heads for a bounded number of cycles (ev_ready must be high).
  task automatic drain(input int cycles);
    got.delete();
    for (int i = 0; i < cycles; i++) begin
      if (ev_valid) got.push_back({ev_key, ev_pressed});
      tick();
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick(); tick();
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", ev_valid); end
    n_cmp++; if (ev_count !== 3'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", ev_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    n_cmp++; if ({ev_key, ev_pressed} !== 4'd0) begin n_bad++; $display("FAIL rst_head: got %h want 0", {ev_key, ev_pressed}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single;
    ev_ready = 1'b1;
    repeat (8) tick();
    key_on = 8'h08;
    tick();
    key_on = '0;
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL single_e0_valid: got %b want 0", ev_valid); end
    tick();
    n_cmp++; if ({ev_valid, ev_key, ev_pressed} !== {1'b1, 3'd3, 1'b1}) begin n_bad++; $display("FAIL single_e1_head: got v=%b k=%0d p=%b want v=1 k=3 p=1", ev_valid, ev_key, ev_pressed); end
    n_cmp++; if (ev_count !== 3'd1) begin n_bad++; $display("FAIL single_e1_count: got %0d want 1", ev_count); end
    tick();
    n_cmp++; if ({ev_valid, ev_count, ev_key, ev_pressed} !== 8'd0) begin n_bad++; $display("FAIL single_popped: got v=%b c=%0d k=%0d p=%b want all 0", ev_valid, ev_count, ev_key, ev_pressed); end
  endtask

  task automatic test_same_cycle;
    ev_ready = 1'b1;
    key_on = 8'h22; key_off = 8'h40;
    tick();
    key_on = '0; key_off = '0;
    tick();
    n_cmp++; if ({ev_valid, ev_key, ev_pressed} !== {1'b1, 3'd1, 1'b1}) begin n_bad++; $display("FAIL same_ev1: got v=%b k=%0d p=%b want 1 1 1", ev_valid, ev_key, ev_pressed); end
    tick();
    n_cmp++; if ({ev_valid, ev_key, ev_pressed} !== {1'b1, 3'd5, 1'b1}) begin n_bad++; $display("FAIL same_ev2: got v=%b k=%0d p=%b want 1 5 1", ev_valid, ev_key, ev_pressed); end
    n_cmp++; if (ev_count !== 3'd1) begin n_bad++; $display("FAIL same_count: got %0d want 1", ev_count); end
    tick();
    n_cmp++; if ({ev_valid, ev_key, ev_pressed} !== {1'b1, 3'd6, 1'b0}) begin n_bad++; $display("FAIL same_ev3: got v=%b k=%0d p=%b want 1 6 0", ev_valid, ev_key, ev_pressed); end
    tick();
    n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL same_empty: got %b want 0", ev_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL same_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_stall_overflow;
    ev_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) key_on = 8'h04; else key_off = 8'h04;
      tick();
      key_on = '0; key_off = '0;
      if (i == 4) begin
        n_cmp++; if (ev_count !== 3'd4) begin n_bad++; $display("FAIL stall_full: got %0d want 4", ev_count); end
      end
      if (i == 5) begin
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL stall_no_ovf: got %b want 0", overflow); end
      end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL stall_ovf: got %b want 1", overflow); end
    n_cmp++; if (ev_count !== 3'd4) begin n_bad++; $display("FAIL stall_count: got %0d want 4", ev_count); end
    ev_ready = 1'b1;
    drain(12);
    n_cmp++; if (got.size() !== 6) begin n_bad++; $display("FAIL stall_drain_n: got %0d want 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_cmp++; if (got[i] !== {3'd2, (i % 2 == 0) ? 1'b1 : 1'b0}) begin n_bad++; $display("FAIL stall_ev%0d: got %h want %h", i, got[i], {3'd2, (i % 2 == 0) ? 1'b1 : 1'b0}); end
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL stall_clear: got %b want 0", overflow); end
  endtask

  task automatic test_full_passthrough;
    ev_ready = 1'b0;
    key_on = 8'hF0;
    tick();
    key_on = '0;
    repeat (4) tick();
    key_on = 8'h01;
    tick();
    key_on = '0;
    n_cmp++; if ({ev_count, ev_key} !== {3'd4, 3'd4}) begin n_bad++; $display("FAIL pass_pre: got c=%0d k=%0d want c=4 k=4", ev_count, ev_key); end
    ev_ready = 1'b1;
    tick();
    n_cmp++; if ({ev_count, ev_key, ev_pressed} !== {3'd4, 3'd5, 1'b1}) begin n_bad++; $display("FAIL pass_swap: got c=%0d k=%0d p=%b want c=4 k=5 p=1", ev_count, ev_key, ev_pressed); end
    drain(8);
    n_cmp++; if (got.size() !== 4) begin n_bad++; $display("FAIL pass_drain_n: got %0d want 4", got.size()); end
    if (got.size() == 4) begin
      n_cmp++; if ({got[0], got[1], got[2], got[3]} !== {4'hB, 4'hD, 4'hF, 4'h1}) begin n_bad++; $display("FAIL pass_order: got %h %h %h %h want b d f 1", got[0], got[1], got[2], got[3]); end
    end
  endtask

  task automatic test_overflow_clear;
    ev_ready = 1'b0;
    key_on = 8'hF0;
    tick();
    key_on = '0;
    repeat (4) tick();
    key_on = 8'h04; tick();
    key_on = '0; key_off = 8'h04; tick();
    key_off = '0; key_on = 8'h04; clear_overflow = 1'b1; tick();
    key_on = '0; clear_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
    tick();
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    ev_ready = 1'b1;
    drain(12);
    n_cmp++; if (got.size() !== 6) begin n_bad++; $display("FAIL ovf_drain_n: got %0d want 6", got.size()); end
  endtask

  task automatic test_reset_midstream;
    int seen;
    ev_ready = 1'b0;
    key_on = 8'hE0; tick();
    key_on = '0; tick(); tick();
    key_on = 8'h10; tick();
    key_on = '0;
    n_cmp++; if (ev_count !== 3'd3) begin n_bad++; $display("FAIL mid_pre_count: got %0d want 3", ev_count); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if ({ev_valid, ev_count, overflow} !== 5'd0) begin n_bad++; $display("FAIL mid_reset: got v=%b c=%0d o=%b want 0", ev_valid, ev_count, overflow); end
    #2 reset_n = 1'b1;
    ev_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ev_valid) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mid_stale: got %0d events want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_cycle();
    test_stall_overflow();
    test_full_passthrough();
    test_overflow_clear();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
